router_pkt_gen: RTL
===================

ROUTER_PKT_GEN -- requirements
Module: router_pkt_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 2, destination address field width.
REQ-002 SHALL have parameter LEN_W, default 6, payload length field width; DATA_W = LEN_W+ADDR_W (8 by default).
REQ-003 SHALL have parameter NUM_PORTS, default 3, number of legal destinations (2 to 2**ADDR_W).
REQ-004 clock  in  1  single clock; all state on rising edge.
REQ-005 resetn  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  request one packet; honoured in IDLE only.
REQ-007 dst_addr  in  ADDR_W  destination, sampled with start.
REQ-008 pay_len  in  LEN_W  payload byte count, sampled with start.
REQ-009 seed_load  in  1  load LFSR from seed; honoured in IDLE only.
REQ-010 seed  in  16  LFSR seed; value 0 replaced by 16'hACE1.
REQ-011 busy  in  1  router backpressure; high stalls generator.
REQ-012 pkt_valid  out  1  packet-valid to router.
REQ-013 data_out  out  DATA_W  byte to router.
REQ-014 gen_busy  out  1  high whenever state != IDLE.
REQ-015 done  out  1  one-cycle pulse after parity byte accepted.
REQ-016 addr_err  out  1  one-cycle pulse when start carries dst_addr >= NUM_PORTS.
REQ-017 pkt_cnt  out  16  completed packets, wraps 16'hFFFF->0.

Function
REQ-018 States SHALL be IDLE, HEADER, PAYLOAD, PARITY; all outputs registered.
REQ-019 A byte SHALL be accepted on a rising edge where state is HEADER/PAYLOAD/PARITY and busy==0; with busy==1, state, data_out, pkt_valid, counters, LFSR held.
REQ-020 IDLE + start + legal dst_addr -> HEADER next cycle, data_out={pay_len,dst_addr}, pkt_valid=1, parity register = header.
REQ-021 IDLE + start + illegal dst_addr -> stay IDLE, addr_err=1 next cycle, no byte emitted.
REQ-022 HEADER accepted -> PAYLOAD if pay_len>0, else PARITY.
REQ-023 PAYLOAD: data_out = LFSR[DATA_W-1:0], pkt_valid=1; each acceptance XORs byte into parity, advances LFSR one step, increments byte counter; after pay_len-th acceptance -> PARITY.
REQ-024 LFSR SHALL be 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0.
REQ-025 PARITY: pkt_valid=0, data_out = XOR of header and all payload bytes; acceptance -> IDLE, done=1 that next cycle, pkt_cnt+1.
REQ-026 IDLE: pkt_valid=0, data_out=0; minimum one IDLE cycle between packets.
REQ-027 start or seed_load outside IDLE SHALL be ignored; seed_load and start together in IDLE: seed loads first, packet uses new seed.
REQ-028 pay_len = 2**LEN_W-1 (63) SHALL be supported without counter overflow.

Reset
REQ-029 resetn low SHALL immediately force IDLE, pkt_valid=0, data_out=0, gen_busy=0, done=0, addr_err=0, pkt_cnt=0, parity=0, byte counter=0, LFSR=16'hACE1, including mid-packet; no partial packet resumes.

Configuration
REQ-030 Macro PKT_GEN_ERR_INJ_EN defined: input err_inj (1 bit) sampled with start; when high, that packet's parity byte is bitwise inverted; pkt_cnt still increments.
REQ-031 PKT_GEN_ERR_INJ_EN undefined: err_inj port absent, parity always correct.

Verification
REQ-032 Reset, seed default, start dst_addr=1 pay_len=16, busy=0 -> header 8'h41, 16 LFSR bytes, parity = XOR of all 17, pkt_valid low on parity, done one cycle, pkt_cnt=1.
REQ-033 pay_len=14, busy high 3 cycles during payload byte 5 -> byte 5 held 4 cycles, total 14 payload bytes, parity correct.
REQ-034 pay_len=0 dst_addr=2 -> header 8'h02 then parity 8'h02, done.
REQ-035 start with dst_addr=3, NUM_PORTS=3 -> addr_err pulse, gen_busy stays 0, pkt_valid never high.
REQ-036 resetn low mid-payload of pay_len=16 -> all outputs reset asynchronously; next start emits fresh packet from LFSR 16'hACE1.
REQ-037 With PKT_GEN_ERR_INJ_EN, err_inj=1, pay_len=4 -> parity byte = ~(correct parity).

Source files
------------

// File: rtl/router_pkt_gen_if.sv
// Generator <-> router handshake bundle; master = packet generator, slave = router/controller side.
// err_inj is present only when PKT_GEN_ERR_INJ_EN is defined.
interface router_pkt_gen_if #(
    parameter int ADDR_W = 2,
    parameter int LEN_W  = 6
);
    localparam int DATA_W = LEN_W + ADDR_W;

    logic              start;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  pay_len;
    logic              seed_load;
    logic [15:0]       seed;
    logic              busy;
`ifdef PKT_GEN_ERR_INJ_EN
    logic              err_inj;
`endif
    logic              pkt_valid;
    logic [DATA_W-1:0] data_out;
    logic              gen_busy;
    logic              done;
    logic              addr_err;
    logic [15:0]       pkt_cnt;

    modport master (
`ifdef PKT_GEN_ERR_INJ_EN
        input  err_inj,
`endif
        input  start, dst_addr, pay_len, seed_load, seed, busy,
        output pkt_valid, data_out, gen_busy, done, addr_err, pkt_cnt
    );

    modport slave (
`ifdef PKT_GEN_ERR_INJ_EN
        output err_inj,
`endif
        output start, dst_addr, pay_len, seed_load, seed, busy,
        input  pkt_valid, data_out, gen_busy, done, addr_err, pkt_cnt
    );
endinterface

// File: rtl/router_pkt_gen.sv
// Router packet generator: header, LFSR payload, XOR parity byte, with backpressure.
// Optional feature macro PKT_GEN_ERR_INJ_EN: err_inj inverts the parity byte of that packet.
module router_pkt_gen #(
    parameter int ADDR_W    = 2,
    parameter int LEN_W     = 6,
    parameter int NUM_PORTS = 3
) (
    input  logic             clock,
    input  logic             resetn,
    router_pkt_gen_if.master bus
);
    localparam int               DATA_W    = LEN_W + ADDR_W;
    localparam logic [15:0]      LFSR_INIT = 16'hACE1;
    localparam logic [ADDR_W:0]  PORT_LIM  = (ADDR_W + 1)'(NUM_PORTS);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PARITY} state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [DATA_W-1:0] par_out(input logic [DATA_W-1:0] p, input logic inv);
        return inv ? ~p : p;
    endfunction

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d, parity_q, parity_d;
    logic              vld_q, vld_d, gbusy_q, done_q, done_d, aerr_q, aerr_d, inj_q, inj_d;
    logic [15:0]       cnt_q, cnt_d, lfsr_q, lfsr_d;
    logic [LEN_W-1:0]  len_q, len_d, bytes_q, bytes_d;

    logic              accept, addr_bad, last_byte, inj_req;
    logic [DATA_W-1:0] header, par_acc;
    logic [15:0]       lfsr_adv, seed_val;

    assign accept    = (state_q != IDLE) && !bus.busy;
    assign addr_bad  = ({1'b0, bus.dst_addr} >= PORT_LIM);
    assign last_byte = ((bytes_q + LEN_ONE) == len_q);
    assign header    = {bus.pay_len, bus.dst_addr};
    assign par_acc   = parity_q ^ data_q;
    assign lfsr_adv  = lfsr_next(lfsr_q);
    // An all-zero seed would lock the LFSR, so substitute the power-on value.
    assign seed_val  = (bus.seed == 16'h0000) ? LFSR_INIT : bus.seed;
`ifdef PKT_GEN_ERR_INJ_EN
    assign inj_req   = bus.err_inj;
`else
    assign inj_req   = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            data_q   <= '0;
            parity_q <= '0;
            vld_q    <= 1'b0;
            gbusy_q  <= 1'b0;
            done_q   <= 1'b0;
            aerr_q   <= 1'b0;
            inj_q    <= 1'b0;
            cnt_q    <= '0;
            lfsr_q   <= LFSR_INIT;
            len_q    <= '0;
            bytes_q  <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            vld_q    <= vld_d;
            gbusy_q  <= (state_d != IDLE);
            done_q   <= done_d;
            aerr_q   <= aerr_d;
            inj_q    <= inj_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            len_q    <= len_d;
            bytes_q  <= bytes_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start && !addr_bad) state_d = HEADER;
            HEADER:  if (accept) state_d = (len_q == '0) ? PARITY : PAYLOAD;
            PAYLOAD: if (accept && last_byte) state_d = PARITY;
            PARITY:  if (accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every output is computed one cycle ahead and registered; busy simply holds the defaults.
    always_comb begin
        data_d   = data_q;
        parity_d = parity_q;
        vld_d    = vld_q;
        done_d   = 1'b0;
        aerr_d   = 1'b0;
        inj_d    = inj_q;
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_q;
        len_d    = len_q;
        bytes_d  = bytes_q;
        case (state_q)
            IDLE: begin
                data_d  = '0;
                vld_d   = 1'b0;
                bytes_d = '0;
                if (bus.seed_load) lfsr_d = seed_val;
                if (bus.start) begin
                    if (addr_bad) begin
                        aerr_d = 1'b1;
                    end else begin
                        data_d   = header;
                        vld_d    = 1'b1;
                        parity_d = header;
                        len_d    = bus.pay_len;
                        inj_d    = inj_req;
                    end
                end
            end
            HEADER: if (accept) begin
                if (len_q == '0) begin
                    data_d = par_out(parity_q, inj_q);
                    vld_d  = 1'b0;
                end else begin
                    data_d = lfsr_q[DATA_W-1:0];
                end
            end
            PAYLOAD: if (accept) begin
                parity_d = par_acc;
                lfsr_d   = lfsr_adv;
                bytes_d  = bytes_q + LEN_ONE;
                if (last_byte) begin
                    data_d = par_out(par_acc, inj_q);
                    vld_d  = 1'b0;
                end else begin
                    data_d = lfsr_adv[DATA_W-1:0];
                end
            end
            PARITY: if (accept) begin
                data_d = '0;
                vld_d  = 1'b0;
                done_d = 1'b1;
                cnt_d  = cnt_q + 16'd1;
            end
            default: ;
        endcase
    end

    assign bus.pkt_valid = vld_q;
    assign bus.data_out  = data_q;
    assign bus.gen_busy  = gbusy_q;
    assign bus.done      = done_q;
    assign bus.addr_err  = aerr_q;
    assign bus.pkt_cnt   = cnt_q;
endmodule
